// File: rtl/house_sort_fsm.sv
// house_sort_fsm: debounced push-button starts a spin through the four houses, landing on a pseudo-random one.
// Optional `SPIN_SLOWDOWN_EN doubles the step period while four or fewer steps remain.
module house_sort_fsm #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SPIN_TICKS      = 2500000,
  parameter int SPIN_STEPS      = 20
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       btn_sort,
  input  logic       btn_clear,
  output logic       slytherin,
  output logic       gryffindor,
  output logic       hufflepuff,
  output logic       ravenclaw,
  output logic [1:0] house_id,
  output logic       sort_busy,
  output logic       sort_done
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = $clog2(SPIN_STEPS + 4);
`ifdef SPIN_SLOWDOWN_EN
  localparam int TW = $clog2(2 * SPIN_TICKS);
`else
  localparam int TW = SPIN_TICKS > 1 ? $clog2(SPIN_TICKS) : 1;
`endif
  typedef enum logic [1:0] {IDLE, SPIN, DONE} state_t;
  state_t state_q, state_d;
  logic s1_q, s1_d, s2_q, s2_d, db_q, db_d, dbd_q, dbd_d, press;
  logic busy_q, busy_d, done_q, done_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [1:0] hid_q, hid_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [TW-1:0] tick_q, tick_d, tick_max;
  logic [3:0] hot_q, hot_d;
`ifdef SPIN_SLOWDOWN_EN
  assign tick_max = (rem_q <= RW'(4)) ? TW'(2 * SPIN_TICKS - 1) : TW'(SPIN_TICKS - 1);
`else
  assign tick_max = TW'(SPIN_TICKS - 1);
`endif
  always_comb begin
    s1_d = btn_sort;
    s2_d = s1_q;
    dbd_d = db_q;
    db_d = db_q;
    dcnt_d = '0;
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (s2_q != db_q) begin
      if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) db_d = s2_q;
      else dcnt_d = dcnt_q + DW'(1);
    end
    press = db_q & ~dbd_q;
    state_d = state_q;
    hid_d = hid_q;
    rem_d = rem_q;
    tick_d = tick_q;
    if (btn_clear) begin
      state_d = IDLE;
      hid_d = '0;
      rem_d = '0;
      tick_d = '0;
    end else if (state_q != SPIN) begin
      if (press) begin
        state_d = SPIN;
        hid_d = '0;
        rem_d = RW'(SPIN_STEPS) + RW'(lfsr_q[1:0]);
        tick_d = '0;
      end
    end else if (tick_q == tick_max) begin
      hid_d = hid_q + 2'd1;
      rem_d = rem_q - RW'(1);
      tick_d = '0;
      state_d = (rem_q == RW'(1)) ? DONE : SPIN;
    end else begin
      tick_d = tick_q + TW'(1);
    end
    hot_d = (state_d == IDLE) ? 4'b0000 : 4'b0001 << hid_d;
    busy_d = state_d == SPIN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      db_q <= 1'b0;
      dbd_q <= 1'b0;
      dcnt_q <= '0;
      lfsr_q <= 8'h01;
      hid_q <= '0;
      rem_q <= '0;
      tick_q <= '0;
      hot_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      db_q <= db_d;
      dbd_q <= dbd_d;
      dcnt_q <= dcnt_d;
      lfsr_q <= lfsr_d;
      hid_q <= hid_d;
      rem_q <= rem_d;
      tick_q <= tick_d;
      hot_q <= hot_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign slytherin = hot_q[0];
  assign gryffindor = hot_q[1];
  assign hufflepuff = hot_q[2];
  assign ravenclaw = hot_q[3];
  assign house_id = hid_q;
  assign sort_busy = busy_q;
  assign sort_done = done_q;
endmodule
